axi_lite_lat_mem: RTL

AXI_LITE_LAT_MEM -- requirements
Module: axi_lite_lat_mem

---
 rtl/axi_lite_lat_mem.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_lat_mem.sv
// AXI4-Lite slave memory with configurable read/write response latency.
// Define AXIL_LAT_MEM_DECERR_EN to return DECERR for out-of-range accesses (default: wrap).
`timescale 1ns/1ps
module axi_lite_lat_mem #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            DEV_SIZE   = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter int unsigned            RD_LATENCY = 2,
  parameter int unsigned            WR_LATENCY = 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int unsigned BYTE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(BYTE_WIDTH);
  localparam int unsigned IDX_W      = $clog2(DEV_SIZE) - OFF_W;
  localparam int unsigned DEPTH      = DEV_SIZE / BYTE_WIDTH;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {WrIdle, WrLat, WrResp} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdLat, RdData} rd_state_e;

  // Base is DEV_SIZE aligned, so truncating the offset also gives modulo-DEV_SIZE wrapping.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

`ifdef AXIL_LAT_MEM_DECERR_EN
  localparam logic [1:0]          RESP_DECERR = 2'b11;
  localparam logic [ADDR_WIDTH:0] BASE_EXT    = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] END_EXT     = BASE_EXT + (ADDR_WIDTH+1)'(DEV_SIZE);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= BASE_EXT) && ({1'b0, a} < END_EXT);
  endfunction
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic [3:0]            wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [BYTE_WIDTH-1:0] wstrb_q;
  logic [1:0]            bresp_q, rresp_q;

  logic                  aw_hs, w_hs, ar_hs, wr_commit, rd_sample;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BYTE_WIDTH-1:0] wr_strb;
  logic                  wr_ok, rd_ok;
  logic [1:0]            wr_resp, rd_resp;
  logic                  unused_prot;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  assign s_axi_awready = !areset && (wr_state_q == WrIdle) && !aw_held_q;
  assign s_axi_wready  = !areset && (wr_state_q == WrIdle) && !w_held_q;
  assign s_axi_arready = !areset && (rd_state_q == RdIdle);
  assign s_axi_bvalid  = (wr_state_q == WrResp);
  assign s_axi_rvalid  = (rd_state_q == RdData);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // With zero latency the commit/sample happens on the capture edge, straight from the inputs.
  assign wr_addr = aw_held_q ? awaddr_q : s_axi_awaddr;
  assign wr_data = w_held_q ? wdata_q : s_axi_wdata;
  assign wr_strb = w_held_q ? wstrb_q : s_axi_wstrb;
  assign rd_addr = (rd_state_q == RdIdle) ? s_axi_araddr : araddr_q;

`ifdef AXIL_LAT_MEM_DECERR_EN
  assign wr_ok   = in_range(wr_addr);
  assign rd_ok   = in_range(rd_addr);
  assign wr_resp = wr_ok ? RESP_OKAY : RESP_DECERR;
  assign rd_resp = rd_ok ? RESP_OKAY : RESP_DECERR;
`else
  assign wr_ok   = 1'b1;
  assign rd_ok   = 1'b1;
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    wr_commit  = 1'b0;
    case (wr_state_q)
      WrIdle: begin
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          if (WR_LATENCY == 0) begin
            wr_state_d = WrResp;
            wr_commit  = 1'b1;
          end else begin
            wr_state_d = WrLat;
            wr_cnt_d   = 4'(WR_LATENCY - 1);
          end
        end
      end
      WrLat: begin
        if (wr_cnt_q == 4'd0) begin
          wr_state_d = WrResp;
          wr_commit  = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      WrResp: begin
        if (s_axi_bready) begin
          wr_state_d = WrIdle;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_sample  = 1'b0;
    case (rd_state_q)
      RdIdle: begin
        if (ar_hs) begin
          if (RD_LATENCY == 0) begin
            rd_state_d = RdData;
            rd_sample  = 1'b1;
          end else begin
            rd_state_d = RdLat;
            rd_cnt_d   = 4'(RD_LATENCY - 1);
          end
        end
      end
      RdLat: begin
        if (rd_cnt_q == 4'd0) begin
          rd_state_d = RdData;
          rd_sample  = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      RdData: begin
        if (s_axi_rready) rd_state_d = RdIdle;
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (ar_hs) araddr_q <= s_axi_araddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (wr_commit) bresp_q <= wr_resp;
      // Nonblocking read of mem yields pre-write data when a commit lands on the same edge.
      if (rd_sample) begin
        rdata_q <= rd_ok ? mem[word_idx(rd_addr)] : '0;
        rresp_q <= rd_resp;
      end
    end
  end

  // Memory contents survive reset; only the commit is suppressed.
  always_ff @(posedge aclk) begin
    if (!areset && wr_commit && wr_ok) begin
      for (int b = 0; b < BYTE_WIDTH; b++) begin
        if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule
